// File: rtl/riscv_pkg.sv
// Shared encodings for the M stage: load/store funct3 codes, WB mux selects,
// the canonical NOP and the memory-cycle FSM state type.
package riscv_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Low two funct3 bits carry the access size for both loads and stores
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} mem_state_e;
endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication / byte enables, and load
// lane extraction with sign or zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic [31:0] lane;

  assign lane = rdata_i >> {off_i, 3'b000};

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    if (store_i) begin
      case (funct3_i[1:0])
        SZ_B: begin
          be_o    = 4'b0001 << off_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        SZ_H: begin
          be_o    = 4'b0011 << off_i;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (funct3_i)
      F3_LB:   rdata_o = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   rdata_o = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  rdata_o = {24'h0, lane[7:0]};
      F3_LHU:  rdata_o = {16'h0, lane[15:0]};
      default: rdata_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/memory_cycle.sv
// M stage: issues data-memory requests, stalls on wait states, traps
// misaligned accesses and holds the MEM/WB pipeline register.
module memory_cycle
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWrite_M,
  input  logic        MemWrite_M,
  input  logic        MemRead_M,
  input  logic [1:0]  ResultSrc_M,
  input  logic [2:0]  funct3_M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALU_Result_M,
  input  logic [31:0] WriteData_M,
  input  logic [31:0] PCPlus4_M,
  input  logic [31:0] Instr_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        Stall_M,
  output logic        Misalign_M,
  output logic        RegWrite_W,
  output logic [1:0]  ResultSrc_W,
  output logic [4:0]  RD_W,
  output logic [31:0] ALU_Result_W,
  output logic [31:0] ReadData_W,
  output logic [31:0] PCPlus4_W,
  output logic [31:0] Instr_W
);
  mem_state_e  state_q;
  logic        access, misaligned, aligned_acc, bubble, is_load;
  logic [1:0]  off;
  logic [31:0] load_val;

  assign off         = ALU_Result_M[1:0];
  assign access      = MemRead_M | MemWrite_M;
  assign misaligned  = ((funct3_M[1:0] == SZ_H) & off[0]) |
                       ((funct3_M[1:0] == SZ_W) & (off != 2'b00));
  assign aligned_acc = access & ~misaligned;
  assign is_load     = MemRead_M & ~MemWrite_M;

  // Outputs forced low while reset is held so a stalled access is dropped cleanly
  assign dmem_req   = rst_n & (aligned_acc | (state_q == S_WAIT));
  assign Stall_M    = rst_n & aligned_acc & ~dmem_ready;
  assign Misalign_M = rst_n & access & misaligned;
  assign bubble     = Stall_M | Misalign_M;

  assign dmem_addr = {ALU_Result_M[31:2], 2'b00};
  assign dmem_we   = MemWrite_M;

  lsu_align u_align (
    .store_i  (MemWrite_M),
    .funct3_i (funct3_M),
    .off_i    (off),
    .wdata_i  (WriteData_M),
    .rdata_i  (dmem_rdata),
    .be_o     (dmem_be),
    .wdata_o  (dmem_wdata),
    .rdata_o  (load_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (aligned_acc && !dmem_ready) state_q <= S_WAIT;
        S_WAIT:  if (dmem_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_W   <= 1'b0;
      ResultSrc_W  <= 2'b00;
      RD_W         <= 5'd0;
      ALU_Result_W <= 32'h0;
      ReadData_W   <= 32'h0;
      PCPlus4_W    <= 32'h0;
      Instr_W      <= NOP_INSTR;
    end else if (bubble) begin
      RegWrite_W   <= 1'b0;
      ResultSrc_W  <= 2'b00;
      RD_W         <= 5'd0;
      ALU_Result_W <= 32'h0;
      ReadData_W   <= 32'h0;
      PCPlus4_W    <= 32'h0;
      Instr_W      <= NOP_INSTR;
    end else begin
      RegWrite_W   <= RegWrite_M;
      ResultSrc_W  <= ResultSrc_M;
      RD_W         <= RD_M;
      ALU_Result_W <= ALU_Result_M;
      ReadData_W   <= is_load ? load_val : 32'h0;
      PCPlus4_W    <= PCPlus4_M;
      Instr_W      <= Instr_M;
    end
  end
endmodule

// File: tb/tb_memory_cycle.sv
// Randomized bench for memory_cycle against a byte-level behavioural model,
// plus directed cases with literal expectations.
module tb_memory_cycle;
  logic        clk = 0, rst_n;
  logic        RegWrite_M, MemWrite_M, MemRead_M;
  logic [1:0]  ResultSrc_M;
  logic [2:0]  funct3_M;
  logic [4:0]  RD_M;
  logic [31:0] ALU_Result_M, WriteData_M, PCPlus4_M, Instr_M;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        Stall_M, Misalign_M, RegWrite_W;
  logic [1:0]  ResultSrc_W;
  logic [4:0]  RD_W;
  logic [31:0] ALU_Result_W, ReadData_W, PCPlus4_W, Instr_W;

  memory_cycle dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .MemRead_M(MemRead_M),
    .ResultSrc_M(ResultSrc_M), .funct3_M(funct3_M), .RD_M(RD_M),
    .ALU_Result_M(ALU_Result_M), .WriteData_M(WriteData_M),
    .PCPlus4_M(PCPlus4_M), .Instr_M(Instr_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .Stall_M(Stall_M), .Misalign_M(Misalign_M),
    .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W), .RD_W(RD_W),
    .ALU_Result_W(ALU_Result_W), .ReadData_W(ReadData_W),
    .PCPlus4_W(PCPlus4_W), .Instr_W(Instr_W)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rw, mw, mr;
    logic [1:0] rs;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [31:0] alu, wd, pc4, ins, rdata;
    int wn;
  } instr_t;

  typedef struct {
    logic rw;
    logic [1:0] rs;
    logic [4:0] rd;
    logic [31:0] alu, rdat, pc4, ins;
  } wb_t;

  int tests = 0, fails = 0;
  int stall_cnt, req_cnt, mis_cnt;
  logic [3:0]  last_be;
  logic [31:0] last_wd;
  logic chk_en = 0, w_valid = 0;
  logic e_req, e_stall, e_mis, e_we;
  logic [31:0] e_addr, e_wd;
  logic [3:0]  e_be;
  wb_t e_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: size in bytes from funct3, lanes from byte offset
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off, input logic st);
    if (!st) return 4'hF;
    case (f3[1:0])
      2'b00:   return 4'(1 << off);
      2'b01:   return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd, input logic st);
    if (!st) return wd;
    case (f3[1:0])
      2'b00:   return (wd & 32'hFF) * 32'h0101_0101;
      2'b01:   return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] sh, v;
    sh = rd >> (8 * off);
    case (f3)
      3'b000: begin v = sh & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'b001: begin v = sh & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'b100: v = sh & 32'hFF;
      3'b101: v = sh & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("stall", Stall_M, e_stall);
    chk("misalign", Misalign_M, e_mis);
    chk("req", dmem_req, e_req);
    if (e_req) begin
      chk("addr", dmem_addr, e_addr);
      chk("we", dmem_we, e_we);
      chk("be", dmem_be, e_be);
      chk("wdata", dmem_wdata, e_wd);
    end
    if (w_valid) begin
      chk("RegWrite_W", RegWrite_W, e_w.rw);
      chk("ResultSrc_W", ResultSrc_W, e_w.rs);
      chk("RD_W", RD_W, e_w.rd);
      chk("ALU_Result_W", ALU_Result_W, e_w.alu);
      chk("ReadData_W", ReadData_W, e_w.rdat);
      chk("PCPlus4_W", PCPlus4_W, e_w.pc4);
      chk("Instr_W", Instr_W, e_w.ins);
    end
    stall_cnt += int'(Stall_M);
    mis_cnt   += int'(Misalign_M);
    if (dmem_req) begin
      req_cnt++;
      last_be = dmem_be;
      last_wd = dmem_wdata;
    end
  end

  task automatic drive(input instr_t t);
    RegWrite_M = t.rw; MemWrite_M = t.mw; MemRead_M = t.mr;
    ResultSrc_M = t.rs; funct3_M = t.f3; RD_M = t.rd;
    ALU_Result_M = t.alu; WriteData_M = t.wd; PCPlus4_M = t.pc4; Instr_M = t.ins;
  endtask

  function automatic instr_t mk(input logic rw, mw, mr, input logic [2:0] f3,
                                input logic [31:0] alu, wd, rdata, input int wn);
    instr_t t;
    t.rw = rw; t.mw = mw; t.mr = mr; t.rs = mr ? 2'b01 : 2'b00; t.f3 = f3;
    t.rd = 5'd7; t.alu = alu; t.wd = wd; t.pc4 = 32'h0000_1004;
    t.ins = 32'h0000_0033; t.rdata = rdata; t.wn = wn;
    return t;
  endfunction

  // Holds one instruction in M for as many cycles as its wait states demand
  task automatic run_instr(input instr_t t);
    logic acc, mis, al;
    logic [1:0] off;
    int n;
    wb_t w;
    off = t.alu[1:0];
    acc = t.mr | t.mw;
    mis = (t.f3[1:0] == 2'b01 && off[0]) || (t.f3[1:0] == 2'b10 && off != 2'b00);
    al  = acc && !mis;
    n   = al ? t.wn : 0;
    drive(t);
    for (int c = 0; c <= n; c++) begin
      dmem_ready = al ? (c == n) : 1'($urandom);
      dmem_rdata = (c == n) ? t.rdata : $urandom;
      e_req = al; e_stall = al && (c < n); e_mis = acc && mis;
      e_addr = t.alu & 32'hFFFF_FFFC; e_we = t.mw;
      e_be = m_be(t.f3, off, t.mw); e_wd = m_wd(t.f3, t.wd, t.mw);
      if (e_stall || e_mis)
        w = '{1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h13};
      else
        w = '{t.rw, t.rs, t.rd, t.alu, (t.mr && !t.mw) ? m_ld(t.f3, off, t.rdata) : 32'h0,
              t.pc4, t.ins};
      @(posedge clk); #1;
      e_w = w; w_valid = 1;
    end
  endtask

  task automatic zero_cnt();
    stall_cnt = 0; req_cnt = 0; mis_cnt = 0;
  endtask

  instr_t t;
  int kind;

  initial begin
    rst_n = 0;
    t = mk(1, 0, 1, 3'b010, 32'h100, 0, 32'h1234_5678, 0);
    drive(t);
    dmem_ready = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req", dmem_req, 0);
    chk("rst stall", Stall_M, 0);
    chk("rst misalign", Misalign_M, 0);
    chk("rst RegWrite_W", RegWrite_W, 0);
    chk("rst ALU_Result_W", ALU_Result_W, 0);
    chk("rst Instr_W", Instr_W, 32'h13);
    t = mk(0, 0, 0, 3'b000, 0, 0, 0, 0);
    t.ins = 32'h13;
    drive(t);
    rst_n = 1;
    @(posedge clk); #1;
    chk_en = 1;

    // SW, zero wait
    zero_cnt();
    run_instr(mk(0, 1, 0, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0));
    chk("SW req cycles", req_cnt, 1);
    chk("SW be", last_be, 4'b1111);
    chk("SW wdata", last_wd, 32'hDEAD_BEEF);
    chk("SW stalls", stall_cnt, 0);

    // SB at offset 3
    run_instr(mk(0, 1, 0, 3'b000, 32'h103, 32'h0000_00A5, 0, 0));
    chk("SB be", last_be, 4'b1000);
    chk("SB wdata", last_wd, 32'hA5A5_A5A5);

    // LB / LBU with two wait states
    zero_cnt();
    run_instr(mk(1, 0, 1, 3'b000, 32'h102, 0, 32'h0080_FF00, 2));
    chk("LB stalls", stall_cnt, 2);
    chk("LB ReadData_W", ReadData_W, 32'hFFFF_FF80);
    chk("LB RegWrite_W", RegWrite_W, 1);
    run_instr(mk(1, 0, 1, 3'b100, 32'h102, 0, 32'h0080_FF00, 2));
    chk("LBU ReadData_W", ReadData_W, 32'h0000_0080);

    // Misaligned LW
    zero_cnt();
    run_instr(mk(1, 0, 1, 3'b010, 32'h101, 0, 32'h1111_1111, 0));
    chk("mis req", req_cnt, 0);
    chk("mis pulses", mis_cnt, 1);
    chk("mis RegWrite_W", RegWrite_W, 0);
    chk("mis Instr_W", Instr_W, 32'h13);

    // ADD then LW back-to-back
    zero_cnt();
    run_instr(mk(1, 0, 0, 3'b000, 32'h0000_0042, 0, 0, 0));
    chk("ADD ALU_Result_W", ALU_Result_W, 32'h42);
    run_instr(mk(1, 0, 1, 3'b010, 32'h200, 0, 32'hCAFE_F00D, 0));
    chk("LW ReadData_W", ReadData_W, 32'hCAFE_F00D);
    chk("ADD/LW stalls", stall_cnt, 0);

    // Reset while waiting, then a late ready
    chk_en = 0;
    drive(mk(1, 0, 1, 3'b010, 32'h300, 0, 0, 0));
    dmem_ready = 0;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("wait-rst req", dmem_req, 0);
    chk("wait-rst stall", Stall_M, 0);
    chk("wait-rst Instr_W", Instr_W, 32'h13);
    chk("wait-rst RegWrite_W", RegWrite_W, 0);
    dmem_ready = 1; dmem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    chk("wait-rst ReadData_W", ReadData_W, 0);
    t = mk(0, 0, 0, 3'b000, 0, 0, 0, 0);
    t.ins = 32'h13;
    drive(t);
    rst_n = 1;
    @(posedge clk); #1;
    chk("post-rst req", dmem_req, 0);
    chk("post-rst RegWrite_W", RegWrite_W, 0);
    w_valid = 0;
    chk_en = 1;

    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 3);
      t.mr = (kind == 1) || (kind == 3);
      t.mw = (kind >= 2);
      t.rw = 1'($urandom);
      t.rs = 2'($urandom);
      t.f3 = t.mw ? {1'b0, 2'($urandom)} : 3'($urandom);
      t.rd = 5'($urandom);
      t.alu = $urandom;
      if ($urandom_range(0, 1) == 1) t.alu = t.alu & 32'hFFFF_FFFC;
      t.wd = $urandom; t.pc4 = $urandom; t.ins = $urandom; t.rdata = $urandom;
      t.wn = $urandom_range(0, 3);
      run_instr(t);
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
